// File: rtl/meas_bram_logger.sv
// -----------------------------------------------------------------------------
// meas_bram_logger
//
// Captures samples from NUM_CH sensor channels into a dual-port block RAM
// through port B. Each channel has its own decimator and a one-deep pending
// register. A round-robin arbiter issues at most one RAM write per cycle.
// Capture runs one-shot (stop when the buffer is full) or circular (wrap and
// keep going). An arm pulse starts or restarts a capture.
//
// Optional build macro: LOGGER_TIMESTAMP_EN
//   Adds a free-running 12-bit timestamp, cleared on arm, in bram_din[27:16].
//   This is only meaningful with DATA_W <= 16.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   ch_data    channel samples, channel k at [k*DATA_W +: DATA_W]
//   ch_valid   one-cycle strobe per channel marking a new sample
//   arm        one-cycle pulse that starts or restarts capture
//   mode       0 = one-shot, 1 = circular (sampled on arm)
//   decim      store 1 of every decim+1 valid samples (sampled on arm)
//   bram_we    port-B write enable
//   bram_addr  port-B word address
//   bram_din   port-B data: {ch[3:0], ts[11:0] or 0, sample}
//   wr_count   words written since arm, saturating at 2**ADDR_W
//   busy       capture in progress
//   done       one-shot buffer full
//   wrapped    sticky: circular capture wrapped at least once
//   overflow   sticky: a pending sample was replaced before it was written
// -----------------------------------------------------------------------------
module meas_bram_logger #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 11,
  parameter int NUM_CH  = 2,
  parameter int DECIM_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic                     arm,
  input  logic                     mode,
  input  logic [DECIM_W-1:0]       decim,
  output logic                     bram_we,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [31:0]              bram_din,
  output logic [ADDR_W:0]          wr_count,
  output logic                     busy,
  output logic                     done,
  output logic                     wrapped,
  output logic                     overflow
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   FULL_CNT  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_n;
  logic                mode_q;
  logic [DECIM_W-1:0]  decim_q;
  logic [ADDR_W-1:0]   ptr;
  logic [CH_W-1:0]     rr_ptr;
  logic [DECIM_W-1:0]  dcnt      [NUM_CH];
  logic [DATA_W-1:0]   pend_data [NUM_CH];
  logic [NUM_CH-1:0]   pend_flag, pend_flag_n;
  logic [NUM_CH-1:0]   accept, eff_pend, ovf_set;
  logic                run_ok, grant_vld, last_write;
  logic [CH_W-1:0]     grant_ch;
  logic [DATA_W-1:0]   grant_data;
  logic [31:0]         din_n;
  int                  j;

`ifdef LOGGER_TIMESTAMP_EN
  logic [11:0] ts;
  always_ff @(posedge clk) begin
    if (rst || arm) ts <= '0;
    else            ts <= ts + 12'd1;
  end
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Acceptance and arbitration. A sample accepted this cycle is visible to
  // the arbiter immediately, so an idle channel is written on the next edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    run_ok     = (state == RUN) && !arm;
    grant_vld  = 1'b0;
    grant_ch   = '0;
    j          = 0;
    for (int k = 0; k < NUM_CH; k++)
      accept[k] = run_ok && ch_valid[k] && (dcnt[k] == '0);
    eff_pend = pend_flag | accept;
    // Walk offsets from farthest to nearest so the nearest requester after
    // the round-robin pointer is the last (winning) assignment.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (run_ok && eff_pend[j]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(j);
      end
    end
    // Registered sample if one is waiting, otherwise bypass the live input.
    grant_data = pend_flag[grant_ch] ? pend_data[grant_ch]
                                     : ch_data[grant_ch*DATA_W +: DATA_W];
    last_write = grant_vld && !mode_q && (ptr == LAST_ADDR);

    din_n              = '0;
    din_n[DATA_W-1:0]  = grant_data;
`ifdef LOGGER_TIMESTAMP_EN
    din_n[27:16]       = ts;
`endif
    din_n[31:28]       = 4'(grant_ch);

    pend_flag_n = pend_flag;
    ovf_set     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (accept[k]) begin
        // Granted with an older sample waiting: the new one re-arms the flag.
        // Granted with nothing waiting: the new one went straight through.
        pend_flag_n[k] = pend_flag[k] | ~(grant_vld && grant_ch == CH_W'(k));
        ovf_set[k]     = pend_flag[k] & ~(grant_vld && grant_ch == CH_W'(k));
      end else if (grant_vld && grant_ch == CH_W'(k)) begin
        pend_flag_n[k] = 1'b0;
      end
    end
    if (arm || last_write) pend_flag_n = '0;

    state_n = state;
    if (arm)             state_n = RUN;
    else if (last_write) state_n = DONE;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      decim_q   <= '0;
      ptr       <= '0;
      rr_ptr    <= '0;
      pend_flag <= '0;
      wr_count  <= '0;
      wrapped   <= 1'b0;
      overflow  <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      for (int k = 0; k < NUM_CH; k++) dcnt[k] <= '0;
    end else begin
      state     <= state_n;
      pend_flag <= pend_flag_n;
      bram_we   <= grant_vld;
      if (arm) begin
        mode_q   <= mode;
        decim_q  <= decim;
        ptr      <= '0;
        wr_count <= '0;
        wrapped  <= 1'b0;
        overflow <= 1'b0;
        for (int k = 0; k < NUM_CH; k++) dcnt[k] <= '0;
      end else begin
        if (|ovf_set) overflow <= 1'b1;
        for (int k = 0; k < NUM_CH; k++)
          if (run_ok && ch_valid[k])
            dcnt[k] <= (dcnt[k] == '0) ? decim_q : dcnt[k] - 1'b1;
        if (grant_vld) begin
          bram_addr <= ptr;
          bram_din  <= din_n;
          ptr       <= ptr + 1'b1;
          rr_ptr    <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
          if (wr_count != FULL_CNT) wr_count <= wr_count + 1'b1;
          if (mode_q && ptr == LAST_ADDR) wrapped <= 1'b1;
        end
      end
    end
  end

  // NOTE: sample storage is not reset; its contents are only ever read while
  // the matching pending flag (which is reset) is set.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++)
      if (accept[k]) pend_data[k] <= ch_data[k*DATA_W +: DATA_W];
  end

endmodule
